// File: rtl/blink_out.sv
// blink_out -- event-driven LED blinker.
//
// Each one-cycle PULSE_IN event produces one blink: LED held high for
// ON_TICKS blink ticks, followed by a forced-low gap of OFF_TICKS ticks.
// A blink tick is CLK_DIV cycles long. The tick prescaler only runs while
// a blink is in progress and is cleared on entry to ON and OFF, so blink
// length never depends on when the request arrived.
//
// Optional feature (compile-time macro BLINK_OUT_QUEUE_EN):
//   defined   : requests arriving while busy are queued in PENDING
//               (saturating at 15) and replayed back to back.
//   undefined : requests arriving while busy are dropped; PENDING stays 0.
// In both builds a request on the OFF-exit cycle with nothing queued
// starts the next blink directly.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   PULSE_IN in   one-cycle blink request
//   LED      out  registered blink output, high only in ON
//   BUSY     out  registered, high in ON and OFF
//   PENDING  out  registered count of queued, not-yet-started blinks
//
// State table:
//   IDLE | no blink in progress, waiting for PULSE_IN
//   ON   | LED high for ON_TICKS ticks
//   OFF  | LED forced low for OFF_TICKS ticks
`timescale 1ns/1ps

module blink_out #(
  parameter int unsigned CLK_DIV   = 3125000,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PULSE_IN,
  output logic       LED,
  output logic       BUSY,
  output logic [3:0] PENDING
);

`ifdef BLINK_OUT_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [7:0]    ticks, ticks_nxt;
  logic [3:0]    pend_nxt;
  logic [3:0]    pend_inc;
  logic          tick;

  assign tick = (presc == PW'(CLK_DIV - 1));

  // Queue a request that arrives while busy; saturate so extra pulses drop.
  always_comb begin
    pend_inc = PENDING;
    if (QUEUE_EN && PULSE_IN && (PENDING != 4'd15)) begin
      pend_inc = PENDING + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    ticks_nxt = ticks;
    pend_nxt  = QUEUE_EN ? PENDING : 4'd0;

    case (state)
      S_IDLE: begin
        if (PULSE_IN) begin
          state_nxt = S_ON;
          presc_nxt = '0;
          ticks_nxt = '0;
        end
      end

      S_ON: begin
        pend_nxt  = pend_inc;
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          ticks_nxt = ticks + 8'd1;
        end
        if (tick && (ticks == 8'(ON_TICKS - 1))) begin
          state_nxt = S_OFF;
          presc_nxt = '0;
          ticks_nxt = '0;
        end
      end

      S_OFF: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          ticks_nxt = ticks + 8'd1;
        end
        if (tick && (ticks == 8'(OFF_TICKS - 1))) begin
          presc_nxt = '0;
          ticks_nxt = '0;
          if (QUEUE_EN && (PENDING != 4'd0)) begin
            // Replay a queued blink; a simultaneous new request refills
            // the slot just consumed, so the count is unchanged.
            state_nxt = S_ON;
            pend_nxt  = PULSE_IN ? PENDING : PENDING - 4'd1;
          end else if (PULSE_IN) begin
            state_nxt = S_ON;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          pend_nxt = pend_inc;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        presc_nxt = '0;
        ticks_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      presc   <= '0;
      ticks   <= '0;
      PENDING <= 4'd0;
      LED     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      ticks   <= ticks_nxt;
      PENDING <= pend_nxt;
      LED     <= (state_nxt == S_ON);
      BUSY    <= (state_nxt != S_IDLE);
    end
  end

endmodule
